mips_regfile_wb_arbiter: RTL and testbench
==========================================

Name: mips_regfile_wb_arbiter

Overview:
- Shares the single write port of the mips_registers block (32 x 32-bit, 2 read / 1 write) between two writeback requesters.
  - Requester 0: ALU writeback.
  - Requester 1: load/memory writeback.
- Each requester uses a valid/ready handshake. Arbitration is round-robin.
- Keeps a 32-entry pending-write scoreboard so the issue stage can stall on registers that still have a write in flight.
- Sits between the execute/memory stages and the register file write port.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of architectural registers (2**ADDR_W).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  ALU writeback request.
- req0_reg  in  ADDR_W  destination register.
- req0_data  in  DATA_W  write data.
- req0_ready  out  1  request 0 accepted this cycle.
- req1_valid  in  1  load writeback request.
- req1_reg  in  ADDR_W  destination register.
- req1_data  in  DATA_W  write data.
- req1_ready  out  1  request 1 accepted this cycle.
- issue_valid  in  1  an instruction with a destination register issued this cycle.
- issue_reg  in  ADDR_W  destination register of the issued instruction.
- rf_write_reg  out  ADDR_W  to register file write_reg.
- rf_write_data  out  DATA_W  to register file write_data.
- rf_reg_write  out  1  to register file signal_reg_write.
- busy_mask  out  NUM_REGS  bit i = 1 while register i has a pending write.

Behaviour:
- Reset:
  - rf_reg_write=0, rf_write_reg=0, rf_write_data=0.
  - busy_mask=0.
  - last_grant=1, so requester 0 wins the first conflict.
  - Stats counters (if enabled) = 0.
  - Reset asserted mid-operation discards any registered write: rf_reg_write=0 in the following cycle.
- Readiness is combinational from valid and last_grant:
  - Only one valid: that requester is granted.
  - Both valid: the requester other than last_grant is granted; the other sees ready=0 and must hold valid/reg/data stable.
  - At most one ready is high per cycle.
  - ready is 0 whenever the matching valid is 0.
- last_grant updates to the granted index on every grant, and holds when there is no grant.
- Transfer occurs when valid && ready in cycle N.
- Write port outputs are registered. In cycle N+1:
  - rf_reg_write=1.
  - rf_write_reg / rf_write_data carry the granted requester's values.
  - The register file captures the value on the rising edge that ends cycle N+1.
- Register 0 ($zero):
  - A request to reg 0 is still granted and handshaken.
  - rf_reg_write stays 0 for it.
  - No busy bit is affected.
- Scoreboard:
  - issue_valid with issue_reg != 0 sets busy_mask[issue_reg] on the next edge.
  - A transfer in cycle N clears busy_mask[reg] on the same edge as the registered write output (end of cycle N).
  - Same register set and cleared on the same edge: set wins, because a newer producer is pending.
  - Issue to an already-busy register leaves the bit set (single bit, no count). The issue stage does not issue a second writer to a busy register.
  - busy_mask[0] is always 0.
- No back-to-back restriction: a grant every cycle gives rf_reg_write=1 every cycle.
- Throughput is 1 write per cycle. Latency from handshake to write edge is 1 cycle.

Optional Feature:
- MIPS_RF_ARB_STATS_EN defined adds three 32-bit outputs:
  - grant0_cnt and grant1_cnt: incremented on each transfer of that requester, including reg-0 transfers.
  - conflict_cnt: incremented in every cycle where both valids are high.
  - All three wrap from 0xFFFFFFFF to 0 and reset to 0.
- Undefined: the ports and counters do not exist; the remaining behaviour is identical.

Decomposition:
- Package mips_rf_pkg:
  - Constants: DATA_W=32, ADDR_W=5, NUM_REGS=32, ZERO_REG=5'd0.
  - Typedef wb_req_t {reg, data}.
- Sub-module mips_rr_arbiter2: two-input round-robin grant logic with the last_grant register. It is reused later for memory-port sharing.

Test Plan:
- Single request: reset, then req0 valid with reg=2, data=0x2A → req0_ready=1 in the same cycle; next cycle rf_reg_write=1, rf_write_reg=2, rf_write_data=0x2A; a read of reg 2 afterwards returns 0x2A.
- Conflict and rotation: both valid every cycle, req0 reg=3 data=0x15, req1 reg=4 data=0x3F → grants go 0,1,0,1; rf_write_reg sequence is 3,4,3,4; the unselected requester sees ready=0 and its data is held.
- Zero register: req1 valid with reg=0, data=0xFFFFFFFF → req1_ready=1, rf_reg_write stays 0, a read of reg 0 returns 0, busy_mask unchanged.
- Scoreboard: issue reg=5 → busy_mask=0x20 next cycle; req0 write to reg 5 → bit 5 clears after the handshake edge; issue reg=5 and req0 transfer to reg 5 in the same cycle → busy_mask[5] stays 1.
- Reset mid-stream: transfer in cycle N, reset in cycle N+1 → rf_reg_write=0 and busy_mask=0 after the reset edge; after release, the first conflict is won by req0.
- Stats (with MIPS_RF_ARB_STATS_EN): 10 conflict cycles → conflict_cnt=10, grant0_cnt=5, grant1_cnt=5.

Source files
------------

// File: rtl/mips_regfile_wb_arbiter_pkg.sv
// Shared constants and the writeback request type for the register-file write-port arbiter.
package mips_rf_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    // "reg" is a keyword, so the destination field is wb_reg
    typedef struct packed {
        logic [ADDR_W-1:0] wb_reg;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/mips_regfile_wb_arbiter_if.sv
// Writeback request, issue and register-file write-port bundle.
// The slave side is the arbiter; the master side feeds requests and consumes the write port.
interface mips_regfile_wb_arbiter_if;
    import mips_rf_pkg::*;

    logic                req0_valid;
    logic [ADDR_W-1:0]   req0_reg;
    logic [DATA_W-1:0]   req0_data;
    logic                req0_ready;

    logic                req1_valid;
    logic [ADDR_W-1:0]   req1_reg;
    logic [DATA_W-1:0]   req1_data;
    logic                req1_ready;

    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_reg;

    logic [ADDR_W-1:0]   rf_write_reg;
    logic [DATA_W-1:0]   rf_write_data;
    logic                rf_reg_write;
    logic [NUM_REGS-1:0] busy_mask;

    modport master (
        output req0_valid, req0_reg, req0_data,
        output req1_valid, req1_reg, req1_data,
        output issue_valid, issue_reg,
        input  req0_ready, req1_ready,
        input  rf_write_reg, rf_write_data, rf_reg_write, busy_mask
    );

    modport slave (
        input  req0_valid, req0_reg, req0_data,
        input  req1_valid, req1_reg, req1_data,
        input  issue_valid, issue_reg,
        output req0_ready, req1_ready,
        output rf_write_reg, rf_write_data, rf_reg_write, busy_mask
    );

endinterface

// File: rtl/mips_regfile_wb_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter; last_grant resets to 1 so input 0 wins the first conflict.
module mips_rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase

        last_grant_d = last_grant_q;
        if (grant[0])
            last_grant_d = 1'b0;
        else if (grant[1])
            last_grant_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            last_grant_q <= 1'b1;
        else
            last_grant_q <= last_grant_d;
    end

endmodule

// File: rtl/mips_regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writeback and tracks pending writes.
// Define MIPS_RF_ARB_STATS_EN to add grant/conflict statistics counters.
module mips_regfile_wb_arbiter
    import mips_rf_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    mips_regfile_wb_arbiter_if.slave wb
`ifdef MIPS_RF_ARB_STATS_EN
    ,
    output logic [31:0]          grant0_cnt,
    output logic [31:0]          grant1_cnt,
    output logic [31:0]          conflict_cnt
`endif
);

    logic [1:0]          grant;
    logic                xfer;
    wb_req_t             sel;

    logic                rf_write_q, rf_write_d;
    logic [ADDR_W-1:0]   rf_reg_q,   rf_reg_d;
    logic [DATA_W-1:0]   rf_data_q,  rf_data_d;
    logic [NUM_REGS-1:0] busy_q,     busy_d;

    mips_rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({wb.req1_valid, wb.req0_valid}),
        .grant (grant)
    );

    assign wb.req0_ready = grant[0];
    assign wb.req1_ready = grant[1];
    assign xfer          = |grant;
    assign sel           = grant[1] ? wb_req_t'{wb.req1_reg, wb.req1_data}
                                    : wb_req_t'{wb.req0_reg, wb.req0_data};

    // Writes to $zero are handshaken but never reach the register file
    always_comb begin
        rf_write_d = 1'b0;
        rf_reg_d   = rf_reg_q;
        rf_data_d  = rf_data_q;
        if (xfer && sel.wb_reg != ZERO_REG) begin
            rf_write_d = 1'b1;
            rf_reg_d   = sel.wb_reg;
            rf_data_d  = sel.data;
        end

        // Set applied after clear: a newly issued producer outranks the retiring one
        busy_d = busy_q;
        if (xfer)
            busy_d[sel.wb_reg] = 1'b0;
        if (wb.issue_valid)
            busy_d[wb.issue_reg] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_write_q <= 1'b0;
            rf_reg_q   <= '0;
            rf_data_q  <= '0;
            busy_q     <= '0;
        end else begin
            rf_write_q <= rf_write_d;
            rf_reg_q   <= rf_reg_d;
            rf_data_q  <= rf_data_d;
            busy_q     <= busy_d;
        end
    end

    assign wb.rf_reg_write  = rf_write_q;
    assign wb.rf_write_reg  = rf_reg_q;
    assign wb.rf_write_data = rf_data_q;
    assign wb.busy_mask     = busy_q;

`ifdef MIPS_RF_ARB_STATS_EN
    logic [31:0] grant0_cnt_q,   grant0_cnt_d;
    logic [31:0] grant1_cnt_q,   grant1_cnt_d;
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        grant0_cnt_d   = grant0_cnt_q   + {31'd0, grant[0]};
        grant1_cnt_d   = grant1_cnt_q   + {31'd0, grant[1]};
        conflict_cnt_d = conflict_cnt_q + {31'd0, wb.req0_valid & wb.req1_valid};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant0_cnt_q   <= '0;
            grant1_cnt_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            grant0_cnt_q   <= grant0_cnt_d;
            grant1_cnt_q   <= grant1_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign grant0_cnt   = grant0_cnt_q;
    assign grant1_cnt   = grant1_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mips_regfile_wb_arbiter.sv
// Directed self-checking bench for mips_regfile_wb_arbiter (arbitration, write port, scoreboard, reset).
module tb_mips_regfile_wb_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mips_regfile_wb_arbiter_if wb_if ();

`ifdef MIPS_RF_ARB_STATS_EN
    logic [31:0] grant0_cnt, grant1_cnt, conflict_cnt;
`endif

    mips_regfile_wb_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb_if)
`ifdef MIPS_RF_ARB_STATS_EN
        ,
        .grant0_cnt   (grant0_cnt),
        .grant1_cnt   (grant1_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge, clear of the rising edge the DUT samples on
    task automatic applyStimulus(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                                 input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                                 input logic iv, input logic [4:0] ir);
        @(negedge clk);
        wb_if.req0_valid  = v0;
        wb_if.req0_reg    = r0;
        wb_if.req0_data   = d0;
        wb_if.req1_valid  = v1;
        wb_if.req1_reg    = r1;
        wb_if.req1_data   = d1;
        wb_if.issue_valid = iv;
        wb_if.issue_reg   = ir;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic afterEdge;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        wb_if.req0_valid  = 1'b0;
        wb_if.req0_reg    = '0;
        wb_if.req0_data   = '0;
        wb_if.req1_valid  = 1'b0;
        wb_if.req1_reg    = '0;
        wb_if.req1_data   = '0;
        wb_if.issue_valid = 1'b0;
        wb_if.issue_reg   = '0;
        afterEdge();
        afterEdge();

        $display("[TB] reset state");
        checkOutput("reset_rf_reg_write", 32'(wb_if.rf_reg_write), 32'd0);
        checkOutput("reset_rf_write_reg", 32'(wb_if.rf_write_reg), 32'd0);
        checkOutput("reset_rf_write_data", wb_if.rf_write_data, 32'd0);
        checkOutput("reset_busy_mask", wb_if.busy_mask, 32'd0);

        @(negedge clk);
        reset = 1'b0;

        $display("[TB] conflict and rotation");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 5'd3, 32'h15, 1'b1, 5'd4, 32'h3F, 1'b0, 5'd0);
            #1;
            checkOutput($sformatf("conf%0d_req0_ready", k), 32'(wb_if.req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("conf%0d_req1_ready", k), 32'(wb_if.req1_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
            afterEdge();
            checkOutput($sformatf("conf%0d_rf_reg_write", k), 32'(wb_if.rf_reg_write), 32'd1);
            checkOutput($sformatf("conf%0d_rf_write_reg", k), 32'(wb_if.rf_write_reg), (k % 2 == 0) ? 32'd3 : 32'd4);
            checkOutput($sformatf("conf%0d_rf_write_data", k), wb_if.rf_write_data, (k % 2 == 0) ? 32'h15 : 32'h3F);
        end
`ifdef MIPS_RF_ARB_STATS_EN
        checkOutput("stats_conflict_cnt", conflict_cnt, 32'd4);
        checkOutput("stats_grant0_cnt", grant0_cnt, 32'd2);
        checkOutput("stats_grant1_cnt", grant1_cnt, 32'd2);
`endif

        $display("[TB] single request");
        applyStimulus(1'b1, 5'd2, 32'h2A, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checkOutput("single_req0_ready", 32'(wb_if.req0_ready), 32'd1);
        checkOutput("single_req1_ready", 32'(wb_if.req1_ready), 32'd0);
        afterEdge();
        checkOutput("single_rf_reg_write", 32'(wb_if.rf_reg_write), 32'd1);
        checkOutput("single_rf_write_reg", 32'(wb_if.rf_write_reg), 32'd2);
        checkOutput("single_rf_write_data", wb_if.rf_write_data, 32'h2A);

        $display("[TB] zero register");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0);
        #1;
        checkOutput("zero_req1_ready", 32'(wb_if.req1_ready), 32'd1);
        afterEdge();
        checkOutput("zero_rf_reg_write", 32'(wb_if.rf_reg_write), 32'd0);
        checkOutput("zero_busy_mask", wb_if.busy_mask, 32'd0);

        $display("[TB] scoreboard");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
        afterEdge();
        checkOutput("sb_issue5_busy", wb_if.busy_mask, 32'h20);
        checkOutput("sb_idle_rf_reg_write", 32'(wb_if.rf_reg_write), 32'd0);

        applyStimulus(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        afterEdge();
        checkOutput("sb_clear5_busy", wb_if.busy_mask, 32'h0);
        checkOutput("sb_clear5_rf_write_reg", 32'(wb_if.rf_write_reg), 32'd5);

        applyStimulus(1'b1, 5'd5, 32'h56, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
        afterEdge();
        checkOutput("sb_set_wins_busy", wb_if.busy_mask, 32'h20);
        checkOutput("sb_set_wins_rf_write_data", wb_if.rf_write_data, 32'h56);

        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
        afterEdge();
        checkOutput("sb_issue0_busy", wb_if.busy_mask, 32'h20);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        afterEdge();
        checkOutput("mid_pre_rf_reg_write", 32'(wb_if.rf_reg_write), 32'd1);
        checkOutput("mid_pre_busy", wb_if.busy_mask, 32'h220);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        reset = 1'b1;
        afterEdge();
        checkOutput("mid_rst_rf_reg_write", 32'(wb_if.rf_reg_write), 32'd0);
        checkOutput("mid_rst_busy", wb_if.busy_mask, 32'h0);
        checkOutput("mid_rst_rf_write_reg", 32'(wb_if.rf_write_reg), 32'd0);

        applyStimulus(1'b1, 5'd3, 32'h15, 1'b1, 5'd4, 32'h3F, 1'b0, 5'd0);
        reset = 1'b0;
        #1;
        checkOutput("post_rst_req0_ready", 32'(wb_if.req0_ready), 32'd1);
        checkOutput("post_rst_req1_ready", 32'(wb_if.req1_ready), 32'd0);
        afterEdge();
        checkOutput("post_rst_rf_write_reg", 32'(wb_if.rf_write_reg), 32'd3);

        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checkOutput("idle_req0_ready", 32'(wb_if.req0_ready), 32'd0);
        afterEdge();
        checkOutput("idle_rf_reg_write", 32'(wb_if.rf_reg_write), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
